// File: rtl/pc_fetch_unit.sv
// Fetch PC owner and instruction-fetch front end.
// Issues in-order instruction-memory requests under a credit limit and buffers
// returned {pc, inst} pairs in a small FIFO toward IF/ID. A redirect reloads
// the PC, flushes the FIFO, and arms a drop counter that discards the wrong-path
// responses still in flight.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  input  logic [31:0] npc_i,
  input  logic        redirect_i,
  input  logic        stall_i,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(BUF_DEPTH - 1);

  // Circular pointer advance.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [PTR_W-1:0] fwr_q, fwr_d, frd_q, frd_d;
  logic [PTR_W-1:0] qwr_q, qwr_d, qrd_q, qrd_d;

  logic [31:0] fifo_pc_q   [BUF_DEPTH];
  logic [31:0] fifo_inst_q [BUF_DEPTH];
  logic [31:0] pcq_q       [BUF_DEPTH];

  logic [CNT_W-1:0] credits;
  logic             accept;
  logic             rsp_drop;
  logic             push;
  logic             pop;
  logic             unused_npc_bits;

  // The low two target bits are forced to zero; keep them visibly consumed.
  assign unused_npc_bits = ^npc_i[1:0];

  // Credits count FIFO slots not yet claimed by buffered or in-flight words,
  // so every accepted request is guaranteed a slot when its response returns.
  assign credits        = DEPTH_C - occ_q - out_q;
  assign imem_req_valid = rst_n && !stall_i && !redirect_i && (credits != '0);
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && ((drop_q != '0) || redirect_i);
  assign push           = imem_rsp_valid && !rsp_drop;
  assign pop            = if_valid_o && if_ready_i && !redirect_i;

  assign pc_o       = pc_q;
  assign if_valid_o = (occ_q != '0);
  assign if_pc_o    = fifo_pc_q[frd_q];
  assign if_inst_o  = fifo_inst_q[frd_q];

  // Next-state for PC, credit accounting, drop counter and all pointers.
  always_comb begin
    pc_d   = pc_q;
    occ_d  = occ_q;
    out_d  = out_q + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
    drop_d = drop_q;
    fwr_d  = fwr_q;
    frd_d  = frd_q;
    qwr_d  = accept ? ptr_inc(qwr_q) : qwr_q;
    // Dropped responses still consume their PC-queue entry, so stale
    // wrong-path PCs drain out in order ahead of any new-path entries.
    qrd_d  = imem_rsp_valid ? ptr_inc(qrd_q) : qrd_q;

    if (redirect_i) begin
      pc_d   = {npc_i[31:2], 2'b00};
      occ_d  = '0;
      fwr_d  = '0;
      frd_d  = '0;
      drop_d = out_q - CNT_W'(imem_rsp_valid);
    end else begin
      if (accept) pc_d = pc_q + 32'd4;
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
      if (push) fwr_d = ptr_inc(fwr_q);
      if (pop)  frd_d = ptr_inc(frd_q);
      occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      occ_q  <= '0;
      out_q  <= '0;
      drop_q <= '0;
      fwr_q  <= '0;
      frd_q  <= '0;
      qwr_q  <= '0;
      qrd_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      occ_q  <= occ_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      fwr_q  <= fwr_d;
      frd_q  <= frd_d;
      qwr_q  <= qwr_d;
      qrd_q  <= qrd_d;
    end
  end

  // Payload storage: FIFO words and in-flight request PCs; guarded by counters.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[fwr_q]   <= pcq_q[qrd_q];
      fifo_inst_q[fwr_q] <= imem_rsp_data;
    end
    if (accept) pcq_q[qwr_q] <= pc_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with an in-order memory model and a
// scoreboard of expected {pc, inst} pairs toward IF/ID.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc_o;
  logic [31:0] npc_i = '0;
  logic        redirect_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid_o;
  logic        if_ready_i = 1'b1;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  int epoch = 0;
  int n_acc = 0;
  logic [31:0] exp_pc = RESET_PC;

  req_t        pending[$];
  req_t        exp_q[$];
  logic [31:0] popped[$];
  logic [31:0] accq[$];

  pc_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_o           (pc_o),
    .npc_i          (npc_i),
    .redirect_i     (redirect_i),
    .stall_i        (stall_i),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid_o     (if_valid_o),
    .if_ready_i     (if_ready_i),
    .if_pc_o        (if_pc_o),
    .if_inst_o      (if_inst_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick(input int idx, input bit from_acc);
    if (from_acc) return (accq.size() > idx) ? accq[idx] : 32'bx;
    return (popped.size() > idx) ? popped[idx] : 32'bx;
  endfunction

  // Asserts reset away from any clock edge, checks reset outputs, clears the
  // model, and releases at a falling edge.
  task automatic do_reset();
    #2;
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    check1("rst_req_valid", imem_req_valid, 1'b0);
    check1("rst_if_valid", if_valid_o, 1'b0);
    check32("rst_pc", pc_o, RESET_PC);
    pending.delete();
    exp_q.delete();
    exp_pc = RESET_PC;
    epoch  = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive the memory response, check outputs against the
  // model, then update the model with what the clock edge will commit.
  task automatic cycle();
    req_t r;
    logic exp_rv;
    logic rsp_now;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    rsp_now = (pending.size() != 0) && (pending[0].due <= cyc);
    if (rsp_now) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(pending[0].addr);
    end
    #1;
    exp_rv = !stall_i && !redirect_i && ((exp_q.size() + pending.size()) < 2);
    check1("req_valid", imem_req_valid, exp_rv);
    check32("pc", pc_o, exp_pc);
    check1("if_valid", if_valid_o, exp_q.size() != 0);
    if (imem_req_valid) check32("req_addr", imem_req_addr, exp_pc);
    if (if_valid_o && if_ready_i && !redirect_i && exp_q.size() != 0) begin
      check32("if_pc", if_pc_o, exp_q[0].addr);
      check32("if_inst", if_inst_o, inst_of(exp_q[0].addr));
      popped.push_back(if_pc_o);
      r = exp_q.pop_front();
    end
    if (rsp_now) begin
      r = pending.pop_front();
      if (r.epoch == epoch && !redirect_i) exp_q.push_back(r);
    end
    if (imem_req_valid && imem_req_ready) begin
      r.addr  = exp_pc;
      r.epoch = epoch;
      r.due   = cyc + lat;
      pending.push_back(r);
      accq.push_back(imem_req_addr);
      exp_pc = exp_pc + 32'd4;
      n_acc++;
    end
    if (redirect_i) begin
      epoch++;
      exp_q.delete();
      exp_pc = {npc_i[31:2], 2'b00};
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    // Power-on reset
    do_reset();

    // Streaming with a 1-cycle memory and an always-ready consumer
    popped.delete();
    accq.delete();
    repeat (8) cycle();
    check32("t1_req0", pick(0, 1'b1), 32'h0);
    check32("t1_req1", pick(1, 1'b1), 32'h4);
    check32("t1_req2", pick(2, 1'b1), 32'h8);
    check32("t1_pop0", pick(0, 1'b0), 32'h0);
    check32("t1_pop1", pick(1, 1'b0), 32'h4);

    // Consumer blocked: credits cap issue at two requests
    if_ready_i = 1'b0;
    do_reset();
    n_acc = 0;
    repeat (8) cycle();
    check32("t2_req_count", 32'(n_acc), 32'd2);
    #1 check1("t2_blocked", imem_req_valid, 1'b0);
    if_ready_i = 1'b1;
    cycle();
    #1 check1("t2_credit_back", imem_req_valid, 1'b1);
    cycle();

    // Redirect with two requests in flight on a slow memory
    do_reset();
    lat = 3;
    cycle();
    cycle();
    redirect_i = 1'b1;
    npc_i      = 32'h0000_0100;
    cycle();
    redirect_i = 1'b0;
    popped.delete();
    #1 check32("t3_pc_target", pc_o, 32'h0000_0100);
    repeat (12) cycle();
    check32("t3_first_pop", pick(0, 1'b0), 32'h0000_0100);

    // Redirect coinciding with a response and a pop
    lat = 1;
    do_reset();
    cycle();
    cycle();
    redirect_i = 1'b1;
    npc_i      = 32'h0000_0040;
    cycle();
    redirect_i = 1'b0;
    popped.delete();
    #1 check1("t4_fifo_empty", if_valid_o, 1'b0);
    repeat (6) cycle();
    check32("t4_first_pop", pick(0, 1'b0), 32'h0000_0040);
    check32("t4_second_pop", pick(1, 1'b0), 32'h0000_0044);

    // Stall holds the PC; unaligned redirect target is forced to a word
    redirect_i = 1'b1;
    npc_i      = 32'h0000_0020;
    cycle();
    redirect_i = 1'b0;
    stall_i    = 1'b1;
    repeat (3) cycle();
    #1 check32("t5_hold", pc_o, 32'h0000_0020);
    check1("t5_no_req", imem_req_valid, 1'b0);
    stall_i = 1'b0;
    accq.delete();
    cycle();
    check32("t5_resume", pick(0, 1'b1), 32'h0000_0020);
    redirect_i = 1'b1;
    npc_i      = 32'h0000_0103;
    cycle();
    redirect_i = 1'b0;
    #1 check32("t5_align", pc_o, 32'h0000_0100);
    repeat (4) cycle();

    // PC wrap at the top of the address space, then reset mid-stream
    redirect_i = 1'b1;
    npc_i      = 32'hFFFF_FFFC;
    cycle();
    redirect_i = 1'b0;
    accq.delete();
    repeat (5) cycle();
    check32("t6_top", pick(0, 1'b1), 32'hFFFF_FFFC);
    check32("t6_wrap", pick(1, 1'b1), 32'h0000_0000);
    if_ready_i = 1'b0;
    repeat (4) cycle();
    #1 check1("t6_buffered", if_valid_o, 1'b1);
    do_reset();
    if_ready_i = 1'b1;
    repeat (6) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
